// File: rtl/wb_arbiter_rr.sv
// Round-robin N:1 Wishbone classic arbiter with a per-transfer watchdog.
// The owner keeps the bus for its whole cyc; an unanswered strobe is errored after TIMEOUT cycles.

module wb_arbiter_rr_lane (
  input  logic own_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic rty_i,
  output logic ack_o,
  output logic err_o,
  output logic rty_o
);
  assign ack_o = own_i & ack_i;
  assign err_o = own_i & err_i;
  assign rty_o = own_i & rty_i;
endmodule

module wb_arbiter_rr #(
  parameter  int NUM_MASTERS = 2,
  parameter  int TIMEOUT     = 255,
  localparam int GW          = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
  output logic [32*NUM_MASTERS-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [31:0]               wbs_adr_o,
  output logic [31:0]               wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [31:0]               wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [GW-1:0]             grant_o,
  output logic                      grant_valid_o,
  output logic                      timeout_o
);
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
  } wb_req_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;
  logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;

  logic             busy;
  logic             found;
  logic [GW-1:0]    winner;
  logic [GW-1:0]    cand;
  int               idx;
  logic [GW-1:0]    sel;
  logic             slv_term;
  logic             wd_fire;
  wb_req_t [NUM_MASTERS-1:0] req;
  wb_req_t          fwd;

  assign busy = (state_q == BUSY);

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_lane
    assign req[k] = '{adr: wbm_adr_i[32*k +: 32], dat: wbm_dat_i[32*k +: 32],
                      sel: wbm_sel_i[4*k +: 4],   we:  wbm_we_i[k],
                      cti: wbm_cti_i[3*k +: 3],   bte: wbm_bte_i[2*k +: 2]};

    wb_arbiter_rr_lane u_lane (
      .own_i (busy && (grant_q == GW'(k))),
      .ack_i (wbs_ack_i),
      .err_i (wbs_err_i | wd_fire),
      .rty_i (wbs_rty_i),
      .ack_o (wbm_ack_o[k]),
      .err_o (wbm_err_o[k]),
      .rty_o (wbm_rty_o[k])
    );
  end

  // Rotating scan starting just after the last winner; the last winner itself is checked last.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    idx    = 0;
    cand   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      cand = GW'(idx);
      if (!found && wbm_cyc_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (state_q == IDLE || !wbm_cyc_i[grant_q]) begin
      if (found) begin
        state_d = BUSY;
        grant_d = winner;
        last_d  = winner;
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign sel = busy ? grant_q : '0;
  assign fwd = req[sel];

  assign slv_term = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // A real slave termination in the firing cycle wins over the watchdog.
  assign wd_fire  = (TIMEOUT != 0) && busy && wbm_stb_i[grant_q] &&
                    (wd_cnt_q == WDW'(TIMEOUT)) && !slv_term;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!wbs_stb_o || slv_term || (TIMEOUT == 0)) wd_cnt_d = '0;
    else                                           wd_cnt_d = wd_cnt_q + 1'b1;
  end

  assign wbs_adr_o     = fwd.adr;
  assign wbs_dat_o     = fwd.dat;
  assign wbs_sel_o     = fwd.sel;
  assign wbs_we_o      = fwd.we;
  assign wbs_cti_o     = fwd.cti;
  assign wbs_bte_o     = fwd.bte;
  assign wbs_cyc_o     = busy & wbm_cyc_i[grant_q];
  assign wbs_stb_o     = busy & wbm_stb_i[grant_q] & ~wd_fire;

  assign wbm_dat_o     = {NUM_MASTERS{wbs_dat_i}};
  assign grant_o       = grant_q;
  assign grant_valid_o = busy;
  assign timeout_o     = wd_fire;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= GW'(NUM_MASTERS - 1);
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end
endmodule
